// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR filter. All channels share one coefficient set, one FSM and one MAC schedule.
// Each channel uses a single time-multiplexed MAC. Results are dequantized by 2^FRAC_BITS with truncation toward zero.
module fir_decim_mc #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int FRAC_BITS  = 10,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF = {
    -32'sd2,   -32'sd4,   -32'sd6,   -32'sd5,   32'sd0,    32'sd9,    32'sd14,   -32'sd13,
    32'sd18,   32'sd60,   32'sd140,  32'sd260,  32'sd390,  32'sd500,  32'sd560,  32'sd579,
    32'sd560,  32'sd500,  32'sd390,  32'sd260,  32'sd140,  32'sd60,   32'sd18,   32'sd21,
    32'sd14,   32'sd9,    32'sd0,    -32'sd5,   -32'sd6,   -32'sd4,   -32'sd2,   -32'sd3
  }
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           x_in_rd_en,
  input  logic                           x_in_empty,
  input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
  output logic                           y_out_wr_en,
  input  logic                           y_out_full
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int TAP_W  = $clog2(TAPS);
  localparam int DEC_W  = $clog2(DECIMATION + 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_DIV, S_OUT} state_t;

  state_t                  r_state, w_nextState;
  logic [DEC_W-1:0]        r_decCnt;
  logic [TAP_W-1:0]        r_tap;
  logic                    w_accept, w_lastIn, w_lastTap;
  logic signed [DATA_WIDTH-1:0] w_coef;

  // Popping is gated by reset so that no read strobe can escape while rst is low.
  assign w_accept  = rst && (r_state == S_LOAD) && !x_in_empty;
  assign w_lastIn  = w_accept && (r_decCnt == DEC_W'(DECIMATION - 1));
  assign w_lastTap = (r_tap == TAP_W'(TAPS - 1));
  assign w_coef    = $signed(COEFF[r_tap]);

  always_comb begin
    w_nextState = r_state;
    x_in_rd_en  = 1'b0;
    y_out_wr_en = 1'b0;
    case (r_state)
      S_LOAD: begin
        x_in_rd_en = w_accept;
        if (w_lastIn) w_nextState = S_MAC;
      end
      S_MAC: if (w_lastTap) w_nextState = S_DIV;
      S_DIV: w_nextState = S_OUT;
      S_OUT: begin
        y_out_wr_en = !y_out_full;
        if (!y_out_full) w_nextState = S_LOAD;
      end
      default: w_nextState = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_LOAD;
      r_decCnt <= '0;
      r_tap    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) r_decCnt <= w_lastIn ? '0 : r_decCnt + DEC_W'(1);
      r_tap <= (r_state == S_MAC && !w_lastTap) ? r_tap + TAP_W'(1) : '0;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] r_delay [TAPS];
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [DATA_WIDTH-1:0] r_y;
    logic signed [DATA_WIDTH-1:0] w_samp;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_bias, w_biased;

    assign w_samp   = r_delay[r_tap];
    assign w_prod   = PROD_W'(w_coef) * PROD_W'(w_samp);
    // Biasing negative sums before the arithmetic shift makes the shift truncate toward zero.
    assign w_bias   = r_acc[ACC_W-1] ? ACC_W'((2 ** FRAC_BITS) - 1) : '0;
    assign w_biased = r_acc + w_bias;
    assign y_out[ch*DATA_WIDTH +: DATA_WIDTH] = r_y;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < TAPS; k++) r_delay[k] <= '0;
        r_acc <= '0;
        r_y   <= '0;
      end else begin
        if (w_accept) begin
          r_delay[0] <= x_in[ch*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < TAPS; k++) r_delay[k] <= r_delay[k-1];
        end
        if (w_lastIn) r_acc <= '0;
        else if (r_state == S_MAC) r_acc <= r_acc + ACC_W'(w_prod);
        if (r_state == S_DIV) r_y <= DATA_WIDTH'(w_biased >>> FRAC_BITS);
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Self-checking bench for fir_decim_mc. It drives FWFT-style FIFO handshakes around a 2-channel default instance and a 4-channel pass-through instance.
// A stream-level convolution model supplies every expected output.
module tb_fir_decim_mc;
  localparam int CH = 2;
  localparam int DW = 32;
  localparam int T  = 32;
  localparam int D  = 8;
  localparam int F  = 10;
  localparam logic [0:T-1][DW-1:0] COEFF_TB = {
    -32'sd2,   -32'sd4,   -32'sd6,   -32'sd5,   32'sd0,    32'sd9,    32'sd14,   -32'sd13,
    32'sd18,   32'sd60,   32'sd140,  32'sd260,  32'sd390,  32'sd500,  32'sd560,  32'sd579,
    32'sd560,  32'sd500,  32'sd390,  32'sd260,  32'sd140,  32'sd60,   32'sd18,   32'sd21,
    32'sd14,   32'sd9,    32'sd0,    -32'sd5,   -32'sd6,   -32'sd4,   -32'sd2,   -32'sd3
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic xRd, yWr;
  logic xEmpty = 1'b1;
  logic yFull  = 1'b0;
  logic [CH*DW-1:0] xIn = '0;
  logic [CH*DW-1:0] yOut;

  fir_decim_mc #(.CHANNELS(CH), .DATA_WIDTH(DW), .TAPS(T), .DECIMATION(D),
                 .FRAC_BITS(F), .COEFF(COEFF_TB)) dut (
    .clk(clk), .rst(rst), .x_in_rd_en(xRd), .x_in_empty(xEmpty), .x_in(xIn),
    .y_out(yOut), .y_out_wr_en(yWr), .y_out_full(yFull));

  localparam int CHB = 4;
  logic [CHB*DW-1:0] xB = '0;
  logic [CHB*DW-1:0] yB, expB;
  logic rdB, wrB;
  logic emptyB = 1'b1;

  fir_decim_mc #(.CHANNELS(CHB), .DATA_WIDTH(DW), .TAPS(4), .DECIMATION(1), .FRAC_BITS(F),
                 .COEFF({32'sd1024, 32'sd0, 32'sd0, 32'sd0})) dutB (
    .clk(clk), .rst(rst), .x_in_rd_en(rdB), .x_in_empty(emptyB), .x_in(xB),
    .y_out(yB), .y_out_wr_en(wrB), .y_out_full(1'b0));

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [CH*DW-1:0] inQ[$];
  logic [CH*DW-1:0] outQ[$];
  int hist[CH][512];
  int histLen = 0;
  int outBase = 0;
  int gapMode = 0;
  bit gapPhase = 0;
  bit fullRand = 0;
  bit rdPending = 0;
  int cyc = 0, acceptCnt = 0, eighthEdge = -1, firstWr = -1, emptyPops = 0, holdViol = 0;
  bit holdMode = 0;
  logic [CH*DW-1:0] heldY;

  function automatic int coefOf(input int k);
    return int'($signed(COEFF_TB[k]));
  endfunction

  // Output n is the full-precision convolution of the stream since reset, divided with C-style truncation.
  function automatic int refOut(input int ch, input int n);
    longint acc = 0;
    longint q;
    for (int k = 0; k < T; k++) begin
      int idx = n * D - 1 - k;
      if (idx >= 0 && idx < histLen) acc += longint'(coefOf(k)) * longint'(hist[ch][idx]);
    end
    q = acc / longint'(2 ** F);
    return int'(q[31:0]);
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rdPending && inQ.size() > 0) void'(inQ.pop_front());
    gapPhase = !gapPhase;
    xIn = (inQ.size() > 0) ? inQ[0] : '0;
    case (gapMode)
      1:       xEmpty = (inQ.size() == 0) || gapPhase;
      2:       xEmpty = (inQ.size() == 0) || ($urandom_range(0, 2) == 0);
      default: xEmpty = (inQ.size() == 0);
    endcase
    if (fullRand) yFull = ($urandom_range(0, 1) == 1);
  end

  always @(negedge clk) begin
    rdPending = xRd;
    if (xRd && xEmpty) emptyPops++;
    if (xRd) begin
      acceptCnt++;
      if (acceptCnt == D) eighthEdge = cyc + 1;
    end
    if (yWr) begin
      outQ.push_back(yOut);
      if (firstWr < 0) firstWr = cyc;
    end
    if (holdMode && (yWr || xRd || yOut !== heldY)) holdViol++;
  end

  bit bEnable = 0;
  bit bPend = 0;
  int bOuts = 0;
  logic [CHB*DW-1:0] accQ[$];

  always @(posedge clk) begin
    #1;
    if (bPend) xB = {$urandom, $urandom, $urandom, $urandom};
    emptyB = !bEnable;
  end

  // With a unit-gain single tap and no decimation, every output must reproduce the vector consumed before it.
  always @(negedge clk) begin
    bPend = rdB;
    if (rdB) accQ.push_back(xB);
    if (wrB) begin
      bOuts++;
      if (accQ.size() == 0) checkOutput("B_extraWrite", 1, 0);
      else begin
        expB = accQ.pop_front();
        for (int ch = 0; ch < CHB; ch++)
          checkOutput($sformatf("B_y%0d_ch%0d", bOuts, ch),
                      $signed(yB[ch*DW +: DW]), $signed(expB[ch*DW +: DW]));
      end
    end
  end

  task automatic applyStimulus(input int nVec, input bit rnd, input int imp0, input int imp1);
    logic [CH*DW-1:0] vec;
    for (int i = 0; i < nVec; i++) begin
      for (int ch = 0; ch < CH; ch++) begin
        int v;
        if (rnd) v = int'($urandom_range(0, 65535)) - 32768;
        else     v = (i == 0) ? ((ch == 0) ? imp0 : imp1) : 0;
        hist[ch][histLen] = v;
        vec[ch*DW +: DW] = v;
      end
      histLen++;
      inQ.push_back(vec);
    end
  endtask

  task automatic runCase(input string tag, input int nVec, input bit rnd, input int imp0,
                         input int imp1, input bit latChk, input bit bp);
    int nOut;
    int waitC;
    logic [CH*DW-1:0] vec;
    nOut = nVec / D;
    outQ.delete();
    acceptCnt = 0; eighthEdge = -1; firstWr = -1; emptyPops = 0; holdViol = 0;
    if (bp) yFull = 1'b1;
    applyStimulus(nVec, rnd, imp0, imp1);
    if (bp) begin
      waitC = 0;
      while (acceptCnt < D && waitC < 2000) begin @(posedge clk); waitC++; end
      repeat (T + 4) @(posedge clk);
      @(negedge clk);
      heldY = yOut;
      holdMode = 1;
      repeat (100) @(negedge clk);
      holdMode = 0;
      checkOutput({tag, "_holdViolations"}, holdViol, 0);
      checkOutput({tag, "_heldY"}, $signed(heldY[DW-1:0]), refOut(0, outBase + 1));
      @(posedge clk);
      #2 yFull = 1'b0;
    end
    waitC = 0;
    while (outQ.size() < nOut && waitC < 5000) begin @(posedge clk); waitC++; end
    repeat (D + T + 10) @(posedge clk);
    checkOutput({tag, "_writes"}, outQ.size(), nOut);
    for (int j = 0; j < nOut && j < outQ.size(); j++) begin
      vec = outQ[j];
      for (int ch = 0; ch < CH; ch++)
        checkOutput($sformatf("%s_y%0d_ch%0d", tag, j + 1, ch),
                    $signed(vec[ch*DW +: DW]), refOut(ch, outBase + j + 1));
    end
    checkOutput({tag, "_popWhileEmpty"}, emptyPops, 0);
    if (latChk) checkOutput({tag, "_latency"}, firstWr - eighthEdge, T + 1);
    outBase += nOut;
  endtask

  initial begin
    int lit[5];
    int waitC;
    logic [CH*DW-1:0] vec;
    lit = '{-13, 579, 21, -3, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_yOut", longint'(yOut), 0);
    checkOutput("reset_wrEn", yWr, 0);
    checkOutput("reset_rdEn", xRd, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    runCase("imp", 40, 0, 1024, -1024, 1, 0);
    for (int j = 0; j < 5 && j < outQ.size(); j++) begin
      vec = outQ[j];
      checkOutput($sformatf("imp_spec%0d_ch0", j + 1), $signed(vec[DW-1:0]), lit[j]);
      checkOutput($sformatf("imp_spec%0d_ch1", j + 1), $signed(vec[2*DW-1:DW]), -lit[j]);
    end

    runCase("trunc", 40, 0, 1, 2000, 0, 0);
    if (outQ.size() > 0) begin
      vec = outQ[0];
      checkOutput("trunc_h7_ch0", $signed(vec[DW-1:0]), 0);
      checkOutput("trunc_h7_ch1", $signed(vec[2*DW-1:DW]), -25);
    end

    gapMode = 1;
    runCase("gap", 40, 0, 1024, -1024, 1, 0);
    gapMode = 0;

    runCase("bp", 40, 0, 1024, -1024, 0, 1);

    outQ.delete();
    acceptCnt = 0;
    applyStimulus(40, 0, 1024, -1024);
    waitC = 0;
    while (acceptCnt < D && waitC < 2000) begin @(posedge clk); waitC++; end
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMid_yOut", longint'(yOut), 0);
    checkOutput("rstMid_rdEn", xRd, 0);
    checkOutput("rstMid_wrEn", yWr, 0);
    inQ.delete();
    histLen = 0;
    outBase = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (50) @(posedge clk);
    checkOutput("rstMid_noWrite", outQ.size(), 0);
    runCase("rstImp", 40, 0, 1024, -1024, 1, 0);

    gapMode = 2;
    fullRand = 1;
    runCase("rand1", 48, 1, 0, 0, 0, 0);
    runCase("rand2", 48, 1, 0, 0, 0, 0);
    fullRand = 0;
    gapMode = 0;
    @(posedge clk);
    #2 yFull = 1'b0;

    bEnable = 1;
    waitC = 0;
    while (bOuts < 12 && waitC < 2000) begin @(posedge clk); waitC++; end
    bEnable = 0;
    repeat (20) @(posedge clk);
    checkOutput("B_enoughOutputs", (bOuts >= 12) ? 1 : 0, 1);
    checkOutput("B_pending", accQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
